// File: rtl/fifo_pkg.sv
// Shared state encoding for the FIFO next-state logic and datapath.
package fifo_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_INIT   = 3'b000;
  localparam state_t ST_NO_OP  = 3'b001;
  localparam state_t ST_WRITE  = 3'b010;
  localparam state_t ST_WR_ERR = 3'b011;
  localparam state_t ST_READ   = 3'b100;
  localparam state_t ST_RD_ERR = 3'b101;

endpackage

// File: rtl/fifo_regfile.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // store the write word at the tail slot
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_datapath.sv
// Sequential half of the FIFO controller: state register, pointers, occupancy,
// read-data register and ack/err decode around a register-file FIFO.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   INIT   | after reset or an illegal code; nothing happens
//   NO_OP  | idle cycle, everything holds
//   WRITE  | word written at tail on the loading edge
//   WR_ERR | write requested while full; nothing stored
//   READ   | word at head moved to dout on the loading edge
//   RD_ERR | read requested while empty; dout holds
module fifo_datapath
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            next_state,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [2:0]            state,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   data_count
);

  localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  do_write;
  logic                  do_read;

  // full/empty come only from the registered count, so the loop through the
  // next-state logic stays broken by a flop
  assign full  = (data_count == COUNT_FULL);
  assign empty = (data_count == '0);

  // sanitise the requested code against the current occupancy
  always_comb begin
    state_d = next_state;
    case (next_state)
      ST_WRITE: if (full)  state_d = ST_WR_ERR;
      ST_READ:  if (empty) state_d = ST_RD_ERR;
      3'b110, 3'b111: state_d = ST_INIT;
      default: state_d = next_state;
    endcase
  end

  assign do_write = reset_n && (state_d == ST_WRITE);
  assign do_read  = reset_n && (state_d == ST_READ);

  // state, pointers, count and dout all update on the edge that loads the state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
      dout       <= '0;
    end else begin
      state_q <= state_d;
      if (do_write) begin
        tail       <= tail + 1'b1;
        data_count <= data_count + 1'b1;
      end else if (do_read) begin
        dout       <= rdata;
        head       <= head + 1'b1;
        data_count <= data_count - 1'b1;
      end
    end
  end

  fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clk   (clk),
    .we    (do_write),
    .waddr (tail),
    .wdata (din),
    .raddr (head),
    .rdata (rdata)
  );

  assign state  = state_q;
  assign wr_ack = (state_q == ST_WRITE);
  assign wr_err = (state_q == ST_WR_ERR);
  assign rd_ack = (state_q == ST_READ);
  assign rd_err = (state_q == ST_RD_ERR);

endmodule

// File: tb/tb_fifo_datapath.sv
// Directed bench for fifo_datapath with a data scoreboard and occupancy model.
module tb_fifo_datapath;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  next_state;
  logic [31:0] din;
  logic [2:0]  state;
  logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [31:0] dout;
  logic [3:0]  data_count;

  int          total = 0;
  int          bad = 0;
  logic [31:0] sb_q[$];
  int          m_count = 0;
  logic [31:0] m_dout = '0;

  fifo_datapath #(.DATA_WIDTH(32), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .next_state (next_state),
    .din        (din),
    .state      (state),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .dout       (dout),
    .data_count (data_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] es);
    logic [3:0] eflags;
    eflags = {es == 3'b010, es == 3'b011, es == 3'b100, es == 3'b101};
    chk({tag, ".state"}, 32'(state), 32'(es));
    chk({tag, ".flags"}, 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'(eflags));
    chk({tag, ".count"}, 32'(data_count), 32'(m_count));
    chk({tag, ".full"}, 32'(full), 32'(m_count == 8));
    chk({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
    chk({tag, ".dout"}, dout, m_dout);
  endtask

  task automatic op(input string tag, input logic [2:0] ns, input logic [31:0] d);
    logic [2:0] es;
    case (ns)
      3'b010:         es = (m_count == 8) ? 3'b011 : 3'b010;
      3'b100:         es = (m_count == 0) ? 3'b101 : 3'b100;
      3'b110, 3'b111: es = 3'b000;
      default:        es = ns;
    endcase
    reset_n    = 1'b1;
    next_state = ns;
    din        = d;
    @(posedge clk);
    #1;
    if (es == 3'b010) begin
      sb_q.push_back(d);
      m_count++;
    end else if (es == 3'b100) begin
      m_dout = sb_q.pop_front();
      m_count--;
    end
    check_all(tag, es);
  endtask

  task automatic do_reset(input string tag, input logic [2:0] ns, input logic [31:0] d);
    reset_n    = 1'b0;
    next_state = ns;
    din        = d;
    @(posedge clk);
    #1;
    sb_q.delete();
    m_count = 0;
    m_dout  = '0;
    check_all(tag, 3'b000);
  endtask

  initial begin
    reset_n    = 1'b0;
    next_state = 3'b010;
    din        = 32'hDEAD_BEEF;

    // reset held for two edges with a write pending
    do_reset("rst0", 3'b010, 32'hDEAD_BEEF);
    do_reset("rst1", 3'b010, 32'hDEAD_BEEF);

    // fill, then overflow attempt
    for (int i = 1; i <= 8; i++) op("fill", 3'b010, 32'(i * 'h11));
    op("wr_over", 3'b010, 32'hBAD0_0001);

    // drain in order, then underflow attempt
    for (int i = 1; i <= 8; i++) op("drain", 3'b100, 32'h0);
    op("rd_under", 3'b100, 32'h0);
    op("idle", 3'b001, 32'h1234);

    // pointer wrap
    for (int i = 0; i < 5; i++) op("wrap_w5", 3'b010, 32'h51 + 32'(i));
    for (int i = 0; i < 5; i++) op("wrap_r5", 3'b100, 32'h0);
    for (int i = 0; i < 6; i++) op("wrap_w6", 3'b010, 32'hA0 + 32'(i));
    op("mid_wr_rd", 3'b100, 32'h0);
    for (int i = 0; i < 5; i++) op("wrap_r6", 3'b100, 32'h0);

    // illegal codes with data present
    op("pre_ill", 3'b010, 32'h77);
    op("ill110", 3'b110, 32'h88);
    op("ill111", 3'b111, 32'h99);
    op("post_ill", 3'b100, 32'h0);

    // reset overrides a pending write and discards contents
    for (int i = 0; i < 3; i++) op("pre_rst", 3'b010, 32'hC0 + 32'(i));
    do_reset("rst_mid", 3'b010, 32'hEE);
    op("rd_after_rst", 3'b100, 32'h0);
    op("wr_after_rst", 3'b010, 32'hF1);
    op("rd_after_wr", 3'b100, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
